// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encodings
// and a ceiling-log2 helper used to size the bit counter.
package serial_adder_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Smallest r such that 2**r >= value; returns 1 for value <= 2 so the
  // counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fullAdder.sv
// Single-bit full-adder cell, the only arithmetic element of the serial adder.
module fullAdder (
  output logic sum,
  output logic carry,
  input  logic op1,
  input  logic op2,
  input  logic op3
);

  // Sum is the three-way parity; carry is the majority of the inputs.
  always_comb begin
    sum   = op1 ^ op2 ^ op3;
    carry = (op1 & op2) | (op1 & op3) | (op2 & op3);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: walks one full-adder cell across two WIDTH-bit
// operands LSB first, keeping the carry in a register between steps.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic             msb_cin_q, msb_cin_d;

  logic             fa_sum;
  logic             fa_carry;

  fullAdder u_full_adder (
    .sum   (fa_sum),
    .carry (fa_carry),
    .op1   (a_sr_q[0]),
    .op2   (b_sr_q[0]),
    .op3   (carry_q)
  );

  // Next-state logic: load operands on accept, step one bit per SHIFT cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = op_a;
          b_sr_d  = op_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sum_sr_d = WIDTH'({fa_sum, sum_sr_q} >> 1);
        carry_d  = fa_carry;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          msb_cin_d = carry_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight addition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      sum_sr_q  <= sum_sr_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
    end
  end

  // Handshake decodes straight from the state register; results come from
  // the shift and carry registers, which hold until the next accept.
  always_comb begin
    ready    = (state_q == ST_IDLE);
    done     = (state_q == ST_DONE);
    sum      = sum_sr_q;
    cout     = carry_q;
    overflow = msb_cin_q ^ carry_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       ready8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       ready1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op_a(a8), .op_b(b8), .cin(cin8),
    .ready(ready8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(a1), .op_b(b1), .cin(cin1),
    .ready(ready1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Issues one WIDTH=8 add from a negedge with ready high and waits for done.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic c, output int edges);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    edges = 0;
    @(posedge clk); edges++;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("w8_ready_low_after_accept", {31'd0, ready8}, 32'd0);
    while (!done8 && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    if (!done8) checkOutput("w8_done_timeout", {31'd0, done8}, 32'd1);
  endtask

  // Same sequence for the WIDTH=1 instance.
  task automatic applyStimulusW1(input logic a, input logic b, input logic c,
                                 output int edges);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    edges = 0;
    @(posedge clk); edges++;
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("w1_ready_low_after_accept", {31'd0, ready1}, 32'd0);
    while (!done1 && edges < 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    if (!done1) checkOutput("w1_done_timeout", {31'd0, done1}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int         edges;
    int         lastDone;
    logic [8:0] expQ[$];
    logic [8:0] exp9;
    logic [8:0] full;
    logic [7:0] ta, tb;
    logic       tc;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, c: 1'b0, s: 8'h96, co: 1'b0, ov: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h00, c: 1'b1, s: 8'h80, co: 1'b0, ov: 1'b1};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {31'd0, ready8}, 32'd1);
    checkOutput("reset_done", {31'd0, done8}, 32'd0);
    checkOutput("reset_sum", {24'd0, sum8}, 32'd0);
    checkOutput("reset_cout", {31'd0, cout8}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf8}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=8 vectors with hand-computed results.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, edges);
      checkOutput($sformatf("vec%0d_latency", i), edges, 32'd9);
      checkOutput($sformatf("vec%0d_sum", i), {24'd0, sum8}, {24'd0, vecs[i].s});
      checkOutput($sformatf("vec%0d_cout", i), {31'd0, cout8}, {31'd0, vecs[i].co});
      checkOutput($sformatf("vec%0d_ovf", i), {31'd0, ovf8}, {31'd0, vecs[i].ov});
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_one_cycle", i), {31'd0, done8}, 32'd0);
      checkOutput($sformatf("vec%0d_ready_back", i), {31'd0, ready8}, 32'd1);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("vec%0d_sum_hold", i), {24'd0, sum8}, {24'd0, vecs[i].s});
      checkOutput($sformatf("vec%0d_cout_hold", i), {31'd0, cout8}, {31'd0, vecs[i].co});
    end

    // Start held high with fresh operands every cycle; only operands present
    // while ready is high may be used.
    lastDone = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (done8) begin
        if (expQ.size() == 0) begin
          checkOutput("stream_unexpected_done", {31'd0, done8}, 32'd0);
        end else begin
          exp9 = expQ.pop_front();
          checkOutput("stream_sum", {24'd0, sum8}, {24'd0, exp9[7:0]});
          checkOutput("stream_cout", {31'd0, cout8}, {31'd0, exp9[8]});
        end
        if (lastDone >= 0) checkOutput("stream_done_period", cyc - lastDone, 32'd10);
        lastDone = cyc;
      end
      ta = 8'(cyc * 37 + 5);
      tb = 8'(cyc * 91 + 11);
      tc = 1'(cyc);
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      if (ready8) begin
        full = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        expQ.push_back(full);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    checkOutput("stream_saw_done", {31'd0, (lastDone >= 0)}, 32'd1);
    repeat (12) @(negedge clk);
    checkOutput("stream_idle_after", {31'd0, ready8}, 32'd1);

    // Reset during the fourth SHIFT cycle, then a clean add.
    a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", {31'd0, ready8}, 32'd1);
    checkOutput("midrst_done", {31'd0, done8}, 32'd0);
    checkOutput("midrst_sum", {24'd0, sum8}, 32'd0);
    checkOutput("midrst_cout", {31'd0, cout8}, 32'd0);
    checkOutput("midrst_ovf", {31'd0, ovf8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'h01, 8'h01, 1'b0, edges);
    checkOutput("postrst_sum", {24'd0, sum8}, 32'h02);
    checkOutput("postrst_cout", {31'd0, cout8}, 32'd0);
    checkOutput("postrst_latency", edges, 32'd9);

    // WIDTH=1 corner: a single SHIFT cycle.
    @(negedge clk);
    applyStimulusW1(1'b1, 1'b1, 1'b1, edges);
    checkOutput("w1_latency", edges, 32'd2);
    checkOutput("w1_sum", {31'd0, sum1}, 32'd1);
    checkOutput("w1_cout", {31'd0, cout1}, 32'd1);
    checkOutput("w1_ovf", {31'd0, ovf1}, 32'd0);
    @(negedge clk);
    checkOutput("w1_done_one_cycle", {31'd0, done1}, 32'd0);
    checkOutput("w1_ready_back", {31'd0, ready1}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
